instr_issue: RTL

//  Instruction fetch/issue sequencer: the producer side of the instruction register interface.
//  - Fetches 8-bit words {op[7:6], reg[5:4], addr[3:0]} from program memory at a program counter.
//  - Drives each word on instr_out, with the matching r/w strobe, to the instruction register.
//  - Executes control ops (jump/halt) internally and never issues them.

---
 rtl/instr_issue_if.sv | 24 ++
 rtl/instr_issue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instr_issue_if.sv
// Instruction issue bus: program-memory read port plus the instruction-register
// issue port, driven by instr_issue (master) and the memory/IR side (slave).
interface instr_issue_if #(
    parameter int PC_W = 4
) ();
    logic [PC_W-1:0] mem_addr;
    logic            mem_rd;
    logic [7:0]      mem_data;
    logic            mem_valid;
    logic [7:0]      instr_out;
    logic            r;
    logic            w;
    logic            issue_vld;

    modport master (
        output mem_addr, mem_rd, instr_out, r, w, issue_vld,
        input  mem_data, mem_valid
    );

    modport slave (
        input  mem_addr, mem_rd, instr_out, r, w, issue_vld,
        output mem_data, mem_valid
    );
endinterface

// File: rtl/instr_issue.sv
// Instruction fetch/issue sequencer: fetches words, runs jump/halt internally and
// issues LOAD/STORE/ALU words with r/w strobes. Define ISSUE_CNT_EN for issue_cnt.
module instr_issue #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    instr_issue_if.master   bus,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
`ifdef ISSUE_CNT_EN
    ,
    output logic [7:0]      issue_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_next;
    logic [7:0]      instr_q;
    logic            rd_q;
    logic            wr_q;
    logic            capture;
    logic            start_ok;
    logic            issue_done;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        start_ok   = 1'b0;
        issue_done = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = RESET_PC;
                    start_ok   = 1'b1;
                end
            end
            S_FETCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_valid) begin
                    // Control words are consumed here and never reach the IR
                    if (bus.mem_data[7:6] == 2'b11) begin
                        if (bus.mem_data[5:4] == 2'b11) begin
                            state_next = S_HALT;
                        end else begin
                            pc_next    = PC_W'(bus.mem_data[3:0]);
                            state_next = S_FETCH;
                        end
                    end else begin
                        capture    = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    pc_next    = pc + PC_W'(1);
                    state_next = S_FETCH;
                    issue_done = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            instr_q <= 8'h00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture) begin
                instr_q <= bus.mem_data;
                rd_q    <= (bus.mem_data[7:6] != 2'b00);
                wr_q    <= (bus.mem_data[7:6] == 2'b00);
            end
        end
    end

`ifdef ISSUE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            issue_cnt <= 8'h00;
        end else if (issue_done && (issue_cnt != 8'hFF)) begin
            issue_cnt <= issue_cnt + 8'h01;
        end
    end
`endif

    // instr_q only loads on issued words, so instr_out holds between issues
    assign bus.mem_addr  = pc;
    assign bus.mem_rd    = (state == S_FETCH);
    assign bus.instr_out = instr_q;
    assign bus.issue_vld = (state == S_ISSUE);
    assign bus.r         = (state == S_ISSUE) && rd_q;
    assign bus.w         = (state == S_ISSUE) && wr_q;
    assign busy          = (state == S_FETCH) || (state == S_WAIT) || (state == S_ISSUE);
    assign halted        = (state == S_HALT);

endmodule
